// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control constants:
// operand mux selects, hazard FSM states, NOP.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_BUSY       = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding select for
// the EX stage operand mux.
module hazard_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RW      = 4,
  parameter int ZERO_EN = 0
) (
  input  logic [RW-1:0] srcId,
  input  logic          srcUsed,
  input  logic          exMemWr,
  input  logic          exMemLoad,
  input  logic [RW-1:0] exMemRd,
  input  logic          memWbWr,
  input  logic [RW-1:0] memWbRd,
  output logic [1:0]    fwdSel
);

  logic idOk;

  // Youngest producer wins; loads in MEM have no ALU result to forward
  always_comb begin
    idOk   = srcUsed && !((ZERO_EN != 0) && (srcId == '0));
    fwdSel = FWD_REG;
    if (idOk && exMemWr && !exMemLoad
        && (exMemRd == srcId))
      fwdSel = FWD_MEM;
    else if (idOk && memWbWr
             && (memWbRd == srcId))
      fwdSel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: stalls, flushes,
// busy freeze, operand selects and stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 4,
  parameter int LOAD_LATENCY = 1,
  parameter int BRANCH_FLUSH = 2,
  parameter int ZERO_REG_EN  = 0,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  if_id_regA,
  input  logic [REG_ADDR_W-1:0]  if_id_regB,
  input  logic                   if_id_useA,
  input  logic                   if_id_useB,
  input  logic                   id_ex_memRead,
  input  logic                   id_ex_regWrite,
  input  logic [REG_ADDR_W-1:0]  id_ex_rd,
  input  logic [REG_ADDR_W-1:0]  id_ex_regA,
  input  logic [REG_ADDR_W-1:0]  id_ex_regB,
  input  logic                   id_ex_useB,
  input  logic                   ex_mem_regWrite,
  input  logic                   ex_mem_memRead,
  input  logic [REG_ADDR_W-1:0]  ex_mem_rd,
  input  logic                   mem_wb_regWrite,
  input  logic [REG_ADDR_W-1:0]  mem_wb_rd,
  input  logic                   branch_taken,
  input  logic                   ex_busy,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   enablePC,
  output logic                   if_id_enable,
  output logic                   id_ex_enable,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int MAXC = (LOAD_LATENCY > BRANCH_FLUSH)
                      ? LOAD_LATENCY : BRANCH_FLUSH;
  localparam int CW   = $clog2(MAXC + 1);

  logic [1:0]    state;
  logic [1:0]    nextState;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nextCnt;
  logic          armed;
  logic          loadUse;
  logic          rdLive;
  logic [1:0]    fwdA;
  logic [1:0]    fwdB;

  hazard_fwd_sel #(
    .RW      (REG_ADDR_W),
    .ZERO_EN (ZERO_REG_EN)
  ) uFwdA (
    .srcId     (id_ex_regA),
    .srcUsed   (1'b1),
    .exMemWr   (ex_mem_regWrite),
    .exMemLoad (ex_mem_memRead),
    .exMemRd   (ex_mem_rd),
    .memWbWr   (mem_wb_regWrite),
    .memWbRd   (mem_wb_rd),
    .fwdSel    (fwdA)
  );

  hazard_fwd_sel #(
    .RW      (REG_ADDR_W),
    .ZERO_EN (ZERO_REG_EN)
  ) uFwdB (
    .srcId     (id_ex_regB),
    .srcUsed   (id_ex_useB),
    .exMemWr   (ex_mem_regWrite),
    .exMemLoad (ex_mem_memRead),
    .exMemRd   (ex_mem_rd),
    .memWbWr   (mem_wb_regWrite),
    .memWbRd   (mem_wb_rd),
    .fwdSel    (fwdB)
  );

  // Operand selects held at regfile until the
  // first post-reset cycle has passed
  always_comb begin
    forwardA = armed ? fwdA : FWD_REG;
    forwardB = armed ? fwdB : FWD_REG;
  end

  // Load in EX whose result the ID instruction needs
  always_comb begin
    rdLive  = !((ZERO_REG_EN != 0)
                && (id_ex_rd == '0));
    loadUse = id_ex_memRead && id_ex_regWrite
           && rdLive
           && ((if_id_useA && (id_ex_rd == if_id_regA))
            || (if_id_useB && (id_ex_rd == if_id_regB)));
  end

  // Prioritised control: reset > busy > branch >
  // flush/stall sequence > new load-use > run
  always_comb begin
    nextState     = state;
    nextCnt       = cnt;
    enablePC      = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!armed) begin
      enablePC      = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      nextState     = ST_RUN;
      nextCnt       = '0;
    end else if (ex_busy) begin
      enablePC      = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_bubble = 1'b1;
      nextState     = ST_BUSY;
      nextCnt       = '0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (BRANCH_FLUSH > 2) begin
        nextState = ST_FLUSH;
        nextCnt   = CW'(BRANCH_FLUSH - 2);
      end else begin
        nextState = ST_RUN;
        nextCnt   = '0;
      end
    end else if (state == ST_FLUSH) begin
      if_id_flush = 1'b1;
      if (cnt <= CW'(1)) begin
        nextState = ST_RUN;
        nextCnt   = '0;
      end else begin
        nextCnt = cnt - CW'(1);
      end
    end else if (state == ST_LOAD_STALL) begin
      enablePC     = 1'b0;
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
      if (cnt <= CW'(1)) begin
        nextState = ST_RUN;
        nextCnt   = '0;
      end else begin
        nextCnt = cnt - CW'(1);
      end
    end else if (loadUse) begin
      enablePC     = 1'b0;
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_LATENCY > 1) begin
        nextState = ST_LOAD_STALL;
        nextCnt   = CW'(LOAD_LATENCY - 1);
      end else begin
        nextState = ST_RUN;
        nextCnt   = '0;
      end
    end else begin
      nextState = ST_RUN;
      nextCnt   = '0;
    end
  end

  // FSM state, sequence counter and post-reset arm flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      armed <= 1'b1;
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (armed && !enablePC
             && (stall_cycles != '1))
      stall_cycles <= stall_cycles
                    + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl
// with LOAD_LATENCY=2, BRANCH_FLUSH=3, ZERO_REG_EN=1.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  if_id_regA, if_id_regB;
  logic        if_id_useA, if_id_useB;
  logic        id_ex_memRead, id_ex_regWrite;
  logic [3:0]  id_ex_rd, id_ex_regA, id_ex_regB;
  logic        id_ex_useB;
  logic        ex_mem_regWrite, ex_mem_memRead;
  logic [3:0]  ex_mem_rd;
  logic        mem_wb_regWrite;
  logic [3:0]  mem_wb_rd;
  logic        branch_taken, ex_busy;
  logic [1:0]  forwardA, forwardB;
  logic        enablePC, if_id_enable, id_ex_enable;
  logic        if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [15:0] stall_cycles;

  int errs = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W   (4),
    .LOAD_LATENCY (2),
    .BRANCH_FLUSH (3),
    .ZERO_REG_EN  (1),
    .STALL_CNT_W  (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .if_id_regA      (if_id_regA),
    .if_id_regB      (if_id_regB),
    .if_id_useA      (if_id_useA),
    .if_id_useB      (if_id_useB),
    .id_ex_memRead   (id_ex_memRead),
    .id_ex_regWrite  (id_ex_regWrite),
    .id_ex_rd        (id_ex_rd),
    .id_ex_regA      (id_ex_regA),
    .id_ex_regB      (id_ex_regB),
    .id_ex_useB      (id_ex_useB),
    .ex_mem_regWrite (ex_mem_regWrite),
    .ex_mem_memRead  (ex_mem_memRead),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regWrite (mem_wb_regWrite),
    .mem_wb_rd       (mem_wb_rd),
    .branch_taken    (branch_taken),
    .ex_busy         (ex_busy),
    .forwardA        (forwardA),
    .forwardB        (forwardB),
    .enablePC        (enablePC),
    .if_id_enable    (if_id_enable),
    .id_ex_enable    (id_ex_enable),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .stall_cycles    (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // wait to the mid-cycle sampling point
  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle();
    if_id_regA = 4'd1; if_id_regB = 4'd2;
    if_id_useA = 1'b0; if_id_useB = 1'b0;
    id_ex_memRead = 1'b0; id_ex_regWrite = 1'b0;
    id_ex_rd = 4'd9; id_ex_regA = 4'd10;
    id_ex_regB = 4'd11; id_ex_useB = 1'b1;
    ex_mem_regWrite = 1'b0; ex_mem_memRead = 1'b0;
    ex_mem_rd = 4'd12;
    mem_wb_regWrite = 1'b0; mem_wb_rd = 4'd13;
    branch_taken = 1'b0; ex_busy = 1'b0;
  endtask

  // load to rd in EX, ID reading it through A and/or B
  task automatic loadUse(input logic [3:0] rd,
                         input logic ua,
                         input logic ub);
    id_ex_memRead = 1'b1; id_ex_regWrite = 1'b1;
    id_ex_rd = rd;
    if_id_regA = rd; if_id_useA = ua;
    if_id_regB = rd; if_id_useB = ub;
  endtask

  initial begin
    idle();
    // forward match applied during reset must be masked
    id_ex_regA = 4'd3; ex_mem_rd = 4'd3;
    ex_mem_regWrite = 1'b1;
    #2;
    chk("rst_pc", enablePC, 0);
    chk("rst_ifen", if_id_enable, 0);
    chk("rst_flush", if_id_flush, 1);
    chk("rst_idbub", id_ex_bubble, 1);
    chk("rst_exbub", ex_mem_bubble, 1);
    chk("rst_fwdA", forwardA, 2'b00);
    chk("rst_cnt", stall_cycles, 0);
    cyc();
    reset = 1'b1;
    mid();
    chk("post_rst_pc", enablePC, 0);
    chk("post_rst_flush", if_id_flush, 1);
    chk("post_rst_fwdA", forwardA, 2'b00);

    // forwarding priority and immediate gating
    cyc();
    mem_wb_rd = 4'd3; mem_wb_regWrite = 1'b1;
    id_ex_regB = 4'd3; id_ex_useB = 1'b0;
    mid();
    chk("run_pc", enablePC, 1);
    chk("run_flush", if_id_flush, 0);
    chk("run_exen", id_ex_enable, 1);
    chk("fwdA_mem_wins", forwardA, 2'b10);
    chk("fwdB_imm", forwardB, 2'b00);
    id_ex_useB = 1'b1;
    #1 chk("fwdB_mem", forwardB, 2'b10);
    ex_mem_memRead = 1'b1;
    #1 chk("fwdA_load_to_wb", forwardA, 2'b01);
    mem_wb_rd = 4'd4;
    #1 chk("fwdA_none", forwardA, 2'b00);
    ex_mem_memRead = 1'b0;
    ex_mem_rd = 4'd0; id_ex_regA = 4'd0;
    mem_wb_rd = 4'd0;
    #1 chk("fwdA_zero_reg", forwardA, 2'b00);
    ex_mem_rd = 4'd3; id_ex_regA = 4'd7;
    mem_wb_rd = 4'd7;
    #1 chk("fwdA_wb", forwardA, 2'b01);

    // two-cycle load-use stall through source A
    cyc();
    idle();
    loadUse(4'd5, 1'b1, 1'b0);
    mid();
    chk("lu0_pc", enablePC, 0);
    chk("lu0_ifen", if_id_enable, 0);
    chk("lu0_bub", id_ex_bubble, 1);
    cyc();
    idle();
    mid();
    chk("lu1_pc", enablePC, 0);
    chk("lu1_bub", id_ex_bubble, 1);
    cyc();
    mid();
    chk("lu2_pc", enablePC, 1);
    chk("lu2_bub", id_ex_bubble, 0);
    chk("lu_cnt", stall_cycles, 2);

    // load to r0 and an unused matching source: no stall
    cyc();
    loadUse(4'd0, 1'b1, 1'b1);
    mid();
    chk("lu_r0_pc", enablePC, 1);
    cyc();
    loadUse(4'd6, 1'b0, 1'b0);
    mid();
    chk("lu_unused_pc", enablePC, 1);

    // load-use through source B
    cyc();
    loadUse(4'd6, 1'b0, 1'b1);
    mid();
    chk("luB0_pc", enablePC, 0);
    cyc();
    idle();
    mid();
    chk("luB1_pc", enablePC, 0);
    cyc();
    mid();
    chk("luB2_pc", enablePC, 1);
    chk("luB_cnt", stall_cycles, 4);

    // taken branch with a three-slot flush
    cyc();
    branch_taken = 1'b1;
    mid();
    chk("br0_pc", enablePC, 1);
    chk("br0_flush", if_id_flush, 1);
    chk("br0_bub", id_ex_bubble, 1);
    cyc();
    branch_taken = 1'b0;
    mid();
    chk("br1_flush", if_id_flush, 1);
    chk("br1_bub", id_ex_bubble, 0);
    chk("br1_pc", enablePC, 1);
    cyc();
    mid();
    chk("br2_flush", if_id_flush, 0);

    // branch cancels a load stall in progress
    cyc();
    loadUse(4'd5, 1'b1, 1'b0);
    mid();
    chk("cx0_pc", enablePC, 0);
    cyc();
    idle();
    branch_taken = 1'b1;
    mid();
    chk("cx1_pc", enablePC, 1);
    chk("cx1_flush", if_id_flush, 1);
    cyc();
    branch_taken = 1'b0;
    mid();
    chk("cx2_pc", enablePC, 1);
    chk("cx2_flush", if_id_flush, 1);
    cyc();
    mid();
    chk("cx3_flush", if_id_flush, 0);
    chk("cx_cnt", stall_cycles, 5);

    // busy freeze outranks branch and load-use
    for (int i = 0; i < 4; i++) begin
      cyc();
      ex_busy = 1'b1; branch_taken = 1'b1;
      loadUse(4'd5, 1'b1, 1'b0);
      mid();
      chk("busy_pc", enablePC, 0);
      chk("busy_exen", id_ex_enable, 0);
      chk("busy_exbub", ex_mem_bubble, 1);
      chk("busy_flush", if_id_flush, 0);
    end
    cyc();
    ex_busy = 1'b0;
    mid();
    chk("after_busy_pc", enablePC, 1);
    chk("after_busy_flush", if_id_flush, 1);
    chk("after_busy_bub", id_ex_bubble, 1);
    chk("after_busy_exbub", ex_mem_bubble, 0);
    cyc();
    branch_taken = 1'b0;
    mid();
    chk("ab1_flush", if_id_flush, 1);
    chk("ab1_pc", enablePC, 1);
    cyc();
    idle();
    mid();
    chk("ab2_pc", enablePC, 1);
    chk("busy_cnt", stall_cycles, 9);

    // reset asserted in the middle of a load stall
    cyc();
    loadUse(4'd5, 1'b1, 1'b0);
    mid();
    chk("rs0_pc", enablePC, 0);
    cyc();
    idle();
    #1 reset = 1'b0;
    #1;
    chk("rs_pc", enablePC, 0);
    chk("rs_flush", if_id_flush, 1);
    chk("rs_exbub", ex_mem_bubble, 1);
    chk("rs_cnt", stall_cycles, 0);
    cyc();
    reset = 1'b1;
    mid();
    chk("rs_rel_flush", if_id_flush, 1);
    chk("rs_rel_pc", enablePC, 0);
    cyc();
    mid();
    chk("rs_run_pc", enablePC, 1);
    chk("rs_run_flush", if_id_flush, 0);
    chk("rs_run_cnt", stall_cycles, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
